instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
//  Initiator side of the instruction-memory read interface: owns the PC, drives PCResult to InstructionMemory and
//  captures the returned Instruction into the IF/ID pipeline register. Sits at the head of the 5-stage pipelined datapath.
//  Handles stall, flush and branch/jump redirect from ID/EX.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value loaded on reset
//  NOP_INSTR  32'h0000_0000  bubble encoding (sll $0,$0,0) written into IF/ID on flush/reset
// PORTS
//  Clk              in   1   rising-edge clock
//  Reset            in   1   synchronous, active-high
//  Stall            in   1   hazard unit: hold PC and IF/ID contents
//  Flush            in   1   squash the instruction currently being fetched (IF/ID <- bubble)
//  BranchTaken      in   1   redirect to BranchTarget next cycle
//  BranchTarget     in   32  branch destination (byte address)
//  JumpTaken        in   1   redirect to JumpTarget next cycle
//  JumpTarget       in   32  jump/jr destination (byte address)
//  PCResult         out  32  current PC, to InstructionMemory address input
//  Instruction      in   32  combinational read data from InstructionMemory for PCResult
//  IFID_Instruction out  32  registered instruction for ID
//  IFID_PCPlus4     out  32  registered PC+4 paired with IFID_Instruction
//  IFID_Valid       out  1   1 = IFID_Instruction is a real fetched instruction, 0 = bubble
//  AlignErr         out  1   sticky: a redirect target had bits[1:0] != 0
//  FetchCount       out  32  number of instructions accepted into IF/ID since reset
// BEHAVIOUR
//  Reset (sampled at posedge Clk): PC<=RESET_PC; IFID_Instruction<=NOP_INSTR; IFID_PCPlus4<=0; IFID_Valid<=0;
//   AlignErr<=0; FetchCount<=0. Reset dominates every other input in the same cycle.
//  PCResult = PC register directly (no combinational path from any input to PCResult).
//  Fetch latency: instruction at address A appears on IFID_Instruction one cycle after PCResult==A, with IFID_PCPlus4=A+4.
//  Next-PC priority (non-reset): JumpTaken > BranchTaken > Stall (hold) > PC+4.
//   - Redirect overrides Stall: a taken branch/jump is never lost while stalled.
//   - Jump and branch both asserted: JumpTarget used.
//  Redirect target: PC <= {target[31:2],2'b00}; if target[1:0]!=0 set AlignErr (sticky until Reset).
//  PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0 with no flag. Memory indexes PC[11:2] only (aliasing
//   above 4 KB is the memory's concern, not this block's).
//  IF/ID update priority: Flush > Stall > load.
//   - Flush=1: IFID_Instruction<=NOP_INSTR, IFID_Valid<=0, IFID_PCPlus4<=0 (Stall ignored).
//   - Stall=1, Flush=0: all IF/ID outputs hold.
//   - otherwise: IFID_Instruction<=Instruction, IFID_PCPlus4<=PC+4, IFID_Valid<=1, FetchCount<=FetchCount+1 (wraps).
//  Redirect does not itself squash IF/ID; the hazard unit asserts Flush with it when required.
//  Reset asserted mid-stall or mid-redirect: next cycle is the reset state; first fetch is from RESET_PC.
//  Reset released: PCResult=RESET_PC in that cycle; first IFID_Valid=1 on the following edge (absent Stall/Flush).
// STRUCTURE
//  Shared pipeline package/header: NOP_INSTR, RESET_PC defaults, IF/ID field widths (reused by ID stage and hazard unit).
//  One natural sub-module: ifid_pipe_reg (Instruction, PCPlus4, Valid with flush/stall enables); PC register and
//   next-PC mux stay in the top level. FetchCount is a plain counter in the top level.
// TESTING (bench instantiates this block with a behavioural memory: mem[i] = i*3)
//  Reset then 4 free-running cycles -> PCResult 0,4,8,C; IFID_Instruction 0,3,6 with IFID_PCPlus4 4,8,C; FetchCount=3.
//  Stall high 2 cycles at PC=8 -> PCResult stays 8, IF/ID holds (Instr 3, PCPlus4 8), FetchCount unchanged.
//  BranchTaken=1, BranchTarget=0x40, Flush=1 at PC=C -> next PCResult=0x40, IFID_Valid=0, IFID_Instruction=NOP;
//   next edge IFID_Instruction=0x30 (mem[16]).
//  Stall=1 with JumpTaken=1, JumpTarget=0x20, BranchTaken=1 -> PCResult=0x20 next cycle, IF/ID held.
//  JumpTarget=0x22 -> PCResult=0x20, AlignErr=1 and remains 1 until Reset.
//  Reset asserted during Stall at PC=0x40 -> next cycle PCResult=0, IFID_Valid=0, FetchCount=0, AlignErr=0.

Source files
------------

// File: rtl/instruction_fetch_unit_pkg.sv
// instruction_fetch_unit_pkg: shared fetch-stage types, defaults and address helpers
package instruction_fetch_unit_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR_DEF = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;
  typedef enum logic [1:0] {PC_SEQ, PC_HOLD, PC_BRANCH, PC_JUMP} pc_sel_e;
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc_plus4;
    logic            valid;
  } ifid_t;
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction
  function automatic logic misaligned(input logic [XLEN-1:0] a);
    return a[1:0] != 2'b00;
  endfunction
endpackage

// File: rtl/instruction_fetch_unit_if.sv
// instruction_fetch_unit_if: instruction-memory read bus between fetch unit and memory
interface instruction_fetch_unit_if;
  import instruction_fetch_unit_pkg::*;
  logic [XLEN-1:0] PCResult;
  logic [XLEN-1:0] Instruction;
  modport master(output PCResult, input Instruction);
  modport slave(input PCResult, output Instruction);
endinterface

// File: rtl/instruction_fetch_unit_ifid_pipe_reg.sv
// ifid_pipe_reg: IF/ID pipeline register with flush-to-bubble and stall-hold
module ifid_pipe_reg
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic  Clk,
  input  logic  Reset,
  input  logic  flush_i,
  input  logic  stall_i,
  input  ifid_t load_i,
  output ifid_t ifid_o
);
  localparam ifid_t BUBBLE = '{instr: NOP_INSTR, pc_plus4: '0, valid: 1'b0};
  ifid_t ifid_q, ifid_d;
  // flush squashes to a bubble even when stalled; stall holds; otherwise capture the fetch
  always_comb ifid_d = flush_i ? BUBBLE : stall_i ? ifid_q : load_i;
  // register with reset to a bubble
  always_ff @(posedge Clk) ifid_q <= Reset ? BUBBLE : ifid_d;
  assign ifid_o = ifid_q;
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC owner and IF/ID producer with stall, flush and redirect handling
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     Stall,
  input  logic                     Flush,
  input  logic                     BranchTaken,
  input  logic [XLEN-1:0]          BranchTarget,
  input  logic                     JumpTaken,
  input  logic [XLEN-1:0]          JumpTarget,
  instruction_fetch_unit_if.master imem,
  output logic [XLEN-1:0]          IFID_Instruction,
  output logic [XLEN-1:0]          IFID_PCPlus4,
  output logic                     IFID_Valid,
  output logic                     AlignErr,
  output logic [XLEN-1:0]          FetchCount
);
  logic [XLEN-1:0] pc_q, pc_d, pc_plus4, count_q, count_d;
  logic            align_q, align_d;
  pc_sel_e         sel;
  ifid_t           ifid;
  assign pc_plus4 = pc_q + PC_STEP;
  // next-PC source: jump beats branch, and any redirect beats a stall so it is never lost
  always_comb sel = JumpTaken ? PC_JUMP : BranchTaken ? PC_BRANCH : Stall ? PC_HOLD : PC_SEQ;
  // next state for PC, sticky alignment flag and accepted-fetch counter
  always_comb begin
    pc_d = sel == PC_JUMP ? align_word(JumpTarget) :
           sel == PC_BRANCH ? align_word(BranchTarget) :
           sel == PC_HOLD ? pc_q : pc_plus4;
    align_d = align_q | (sel == PC_JUMP && misaligned(JumpTarget)) |
              (sel == PC_BRANCH && misaligned(BranchTarget));
    count_d = (!Flush && !Stall) ? count_q + 32'd1 : count_q;
  end
  // fetch-stage state, reset dominating every other input
  always_ff @(posedge Clk) begin
    pc_q    <= Reset ? RESET_PC : pc_d;
    align_q <= Reset ? 1'b0 : align_d;
    count_q <= Reset ? '0 : count_d;
  end
  ifid_pipe_reg #(.NOP_INSTR(NOP_INSTR)) u_ifid (
    .Clk    (Clk),
    .Reset  (Reset),
    .flush_i(Flush),
    .stall_i(Stall),
    .load_i ('{instr: imem.Instruction, pc_plus4: pc_plus4, valid: 1'b1}),
    .ifid_o (ifid)
  );
  assign imem.PCResult    = pc_q;
  assign IFID_Instruction = ifid.instr;
  assign IFID_PCPlus4     = ifid.pc_plus4;
  assign IFID_Valid       = ifid.valid;
  assign AlignErr         = align_q;
  assign FetchCount       = count_q;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: scoreboard bench with behavioural memory mem[i] = i*3
module tb_instruction_fetch_unit;
  import instruction_fetch_unit_pkg::*;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } exp_t;
  logic        clk = 1'b0;
  logic        Reset, Stall, Flush, BranchTaken, JumpTaken;
  logic [31:0] BranchTarget, JumpTarget;
  logic [31:0] IFID_Instruction, IFID_PCPlus4, FetchCount;
  logic        IFID_Valid, AlignErr;
  int          n_checks = 0;
  int          n_fail = 0;
  exp_t        sb[$];
  exp_t        last;
  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_cnt = 32'h0;
  logic        m_align = 1'b0;
  instruction_fetch_unit_if bus ();
  assign bus.Instruction = {22'd0, bus.PCResult[11:2]} * 32'd3;
  instruction_fetch_unit dut (
    .Clk             (clk),
    .Reset           (Reset),
    .Stall           (Stall),
    .Flush           (Flush),
    .BranchTaken     (BranchTaken),
    .BranchTarget    (BranchTarget),
    .JumpTaken       (JumpTaken),
    .JumpTarget      (JumpTarget),
    .imem            (bus),
    .IFID_Instruction(IFID_Instruction),
    .IFID_PCPlus4    (IFID_PCPlus4),
    .IFID_Valid      (IFID_Valid),
    .AlignErr        (AlignErr),
    .FetchCount      (FetchCount)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {22'd0, a[11:2]} * 32'd3;
  endfunction
  task automatic step(input bit r, input bit s, input bit f, input bit b, input logic [31:0] bt,
                      input bit j, input logic [31:0] jt);
    Reset = r; Stall = s; Flush = f; BranchTaken = b; BranchTarget = bt; JumpTaken = j; JumpTarget = jt;
    if (r || f) sb.push_back('{instr: 32'h0, pc4: 32'h0, valid: 1'b0});
    else if (!s) sb.push_back('{instr: mem_word(m_pc), pc4: m_pc + 32'd4, valid: 1'b1});
    if (r) begin
      m_pc = 32'h0; m_cnt = 32'h0; m_align = 1'b0;
    end else begin
      if (!f && !s) m_cnt = m_cnt + 32'd1;
      if (j) begin
        m_align = m_align | (jt[1:0] != 2'b00);
        m_pc = {jt[31:2], 2'b00};
      end else if (b) begin
        m_align = m_align | (bt[1:0] != 2'b00);
        m_pc = {bt[31:2], 2'b00};
      end else if (!s) m_pc = m_pc + 32'd4;
    end
    @(posedge clk);
    #1;
    if (sb.size() > 0) last = sb.pop_front();
    check("pc", bus.PCResult, m_pc);
    check("ifid_instr", IFID_Instruction, last.instr);
    check("ifid_pc4", IFID_PCPlus4, last.pc4);
    check("ifid_valid", {31'd0, IFID_Valid}, {31'd0, last.valid});
    check("align", {31'd0, AlignErr}, {31'd0, m_align});
    check("count", FetchCount, m_cnt);
  endtask
  initial begin
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 1, 32'h44, 1, 32'h88);
    check("rst_pc", bus.PCResult, 32'h0);
    check("rst_valid", {31'd0, IFID_Valid}, 32'd0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    check("free_pc", bus.PCResult, 32'h8);
    check("free_instr", IFID_Instruction, 32'h3);
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    check("stall_pc", bus.PCResult, 32'h8);
    check("stall_pc4", IFID_PCPlus4, 32'h8);
    check("stall_cnt", FetchCount, 32'd2);
    step(0, 0, 0, 0, 0, 0, 0);
    check("pre_br_cnt", FetchCount, 32'd3);
    step(0, 0, 1, 1, 32'h40, 0, 0);
    check("br_pc", bus.PCResult, 32'h40);
    check("br_bubble", IFID_Instruction, 32'h0);
    step(0, 0, 0, 0, 0, 0, 0);
    check("br_fetch", IFID_Instruction, 32'h30);
    step(0, 1, 0, 1, 32'h80, 1, 32'h20);
    check("jmp_stall_pc", bus.PCResult, 32'h20);
    check("jmp_stall_hold", IFID_Instruction, 32'h30);
    step(0, 0, 0, 0, 0, 1, 32'h22);
    check("mis_pc", bus.PCResult, 32'h20);
    check("mis_flag", {31'd0, AlignErr}, 32'd1);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 32'h13, 0, 0);
    step(0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC);
    step(0, 0, 0, 0, 0, 0, 0);
    check("wrap_pc", bus.PCResult, 32'h0);
    check("wrap_pc4", IFID_PCPlus4, 32'h0);
    check("wrap_instr", IFID_Instruction, 32'd3069);
    step(0, 0, 0, 0, 0, 1, 32'h40);
    step(0, 1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 1, 32'h10, 0, 0);
    check("rst2_pc", bus.PCResult, 32'h0);
    check("rst2_cnt", FetchCount, 32'd0);
    check("rst2_align", {31'd0, AlignErr}, 32'd0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    check("post_rst_instr", IFID_Instruction, 32'h3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
